button_debouncer: RTL and testbench

Conditions one raw, asynchronous, bouncing push-button input into a clean one-cycle pulse that drives change_state_debounced of the flap indicator FSM.
- Synchronises the input into clk with two flip-flops.
- Requires DEBOUNCE_CYCLES consecutive identical samples before accepting a level change.
- Emits exactly one press pulse per accepted press, and one release pulse per accepted release.

---
 rtl/button_debouncer_pkg.sv | 14 +
 rtl/bit_synchronizer.sv | 20 ++
 rtl/button_debouncer.sv | 97 +++++++++
 tb/tb_button_debouncer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer and its board-level users.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_RELEASED = 2'd0,
    WAIT_PRESS    = 2'd1,
    HELD_PRESSED  = 2'd2,
    WAIT_RELEASE  = 2'd3
  } deb_state_t;

  // 10 ms of stable input at the 50 MHz board clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous input bit; shared by all board buttons.
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) chain <= '0;
    else               chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button into a registered level plus one-cycle press/release pulses.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q;
  deb_state_t    state, state_next;
  logic [CW-1:0] count, count_next;
  logic          press_next, release_next;

  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .async_nreset (async_nreset),
    .d            (button_raw),
    .q            (sync_q)
  );

  // Counter restarts on every state change, so it only measures the current stable run.
  always_comb begin
    state_next   = state;
    count_next   = count;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE_RELEASED: begin
        if (sync_q) begin
          state_next = WAIT_PRESS;
          count_next = '0;
        end
      end
      WAIT_PRESS: begin
        if (!sync_q) begin
          state_next = IDLE_RELEASED;
          count_next = '0;
        end else if (count == CNT_LAST) begin
          state_next = HELD_PRESSED;
          count_next = '0;
          press_next = 1'b1;
        end else begin
          count_next = count + CW'(1);
        end
      end
      HELD_PRESSED: begin
        if (!sync_q) begin
          state_next = WAIT_RELEASE;
          count_next = '0;
        end
      end
      WAIT_RELEASE: begin
        if (sync_q) begin
          state_next = HELD_PRESSED;
          count_next = '0;
        end else if (count == CNT_LAST) begin
          state_next   = IDLE_RELEASED;
          count_next   = '0;
          release_next = 1'b1;
        end else begin
          count_next = count + CW'(1);
        end
      end
      default: begin
        state_next = IDLE_RELEASED;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state         <= IDLE_RELEASED;
      count         <= '0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      button_level  <= (state_next == HELD_PRESSED) || (state_next == WAIT_RELEASE);
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2.
module tb_button_debouncer;

  localparam int DC  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + DC + 1;   // negedges from the driving negedge to the pulse cycle

  logic clk = 1'b0;
  logic async_nreset;
  logic button_raw;
  logic button_level;
  logic press_pulse;
  logic release_pulse;

  logic [31:0] cyc = '0;
  logic [32:0] exp_q[$];    // {kind (1 = press, 0 = release), cycle the pulse is seen}
  logic [32:0] e;
  int n_tests = 0;
  int n_fail  = 0;
  int press_cnt = 0;
  int release_cnt = 0;
  int base;
  logic [31:0] r;

  button_debouncer #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk           (clk),
    .async_nreset  (async_nreset),
    .button_raw    (button_raw),
    .button_level  (button_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drive a clean level change, predict its pulse, and check the level flips exactly at the pulse
  task automatic clean_edge(input logic v, input string tag);
    @(negedge clk);
    button_raw = v;
    exp_q.push_back({v, cyc + 32'(LAT)});
    tick(LAT - 1);
    check({tag, "_level_before"}, 64'(button_level), 64'(!v));
    tick(1);
    check({tag, "_level_after"}, 64'(button_level), 64'(v));
  endtask

  // scoreboard: every pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (press_pulse && release_pulse) check("both_pulses", 64'd1, 64'd0);
    if (press_pulse || release_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {31'b0, press_pulse, cyc}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse", {31'b0, press_pulse, cyc}, 64'(e));
      end
      if (press_pulse)   press_cnt++;
      if (release_pulse) release_cnt++;
    end
    if (exp_q.size() != 0 && exp_q[0][31:0] < cyc) begin
      e = exp_q.pop_front();
      check("missed_pulse", {32'b0, cyc}, 64'(e));
    end
  end

  initial begin
    async_nreset = 1'b0;
    button_raw   = 1'b0;
    tick(3);
    check("rst_level",   64'(button_level),  64'd0);
    check("rst_press",   64'(press_pulse),   64'd0);
    check("rst_release", 64'(release_pulse), 64'd0);
    @(negedge clk);
    async_nreset = 1'b1;
    tick(3);
    check("idle_level", 64'(button_level), 64'd0);

    // clean press, long hold, then release
    clean_edge(1'b1, "t1_press");
    tick(13);
    check("t1_hold_level", 64'(button_level), 64'd1);
    check("t1_press_count", 64'(press_cnt), 64'd1);
    check("t1_no_release", 64'(release_cnt), 64'd0);
    clean_edge(1'b0, "t4_release");
    tick(10);
    check("t4_release_count", 64'(release_cnt), 64'd1);

    // bouncy press: 1,0,1,0 then settle high
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      button_raw = (i % 2 == 0);
    end
    clean_edge(1'b1, "t2_press");
    tick(10);
    clean_edge(1'b0, "t2_release");
    tick(10);

    // glitch of 3 cycles must be ignored
    @(negedge clk);
    button_raw = 1'b1;
    tick(2);
    @(negedge clk);
    button_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("t3_glitch_level", 64'(button_level), 64'd0);
    end

    // reset while WAIT_PRESS has counted to 2
    @(negedge clk);
    button_raw = 1'b1;
    tick(5);
    #2 async_nreset = 1'b0;
    #1 check("t5_rst_level", 64'(button_level), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t5_rst_press", 64'(press_pulse), 64'd0);
    end
    @(negedge clk);
    async_nreset = 1'b1;
    r = cyc;
    exp_q.push_back({1'b1, r + 32'(LAT)});
    tick(LAT - 1);
    check("t5_level_before", 64'(button_level), 64'd0);
    tick(1);
    check("t5_level_after", 64'(button_level), 64'd1);
    tick(5);
    clean_edge(1'b0, "t5_release");
    tick(5);

    // reset during the press pulse itself
    @(negedge clk);
    button_raw = 1'b1;
    exp_q.push_back({1'b1, cyc + 32'(LAT)});
    tick(LAT);
    #2 async_nreset = 1'b0;
    #1 check("t5b_pulse_cleared", 64'(press_pulse), 64'd0);
    check("t5b_level_cleared", 64'(button_level), 64'd0);
    @(negedge clk);
    button_raw = 1'b0;
    tick(2);
    @(negedge clk);
    async_nreset = 1'b1;
    tick(10);
    check("t5b_level_idle", 64'(button_level), 64'd0);

    // three presses with random gaps
    base = press_cnt;
    for (int i = 0; i < 3; i++) begin
      clean_edge(1'b1, "t6_press");
      tick($urandom_range(3, 10));
      clean_edge(1'b0, "t6_release");
      tick($urandom_range(3, 10));
    end
    check("t6_press_count", 64'(press_cnt - base), 64'd3);

    tick(10);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
